// File: rtl/pes_rca_sched.sv
// Two-requester round-robin scheduler feeding a single 4-bit add-with-carry stage.
// Wide operands are added one nibble per cycle, LSB first, and returned with the requester ID.
module pes_rca_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_id
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               id_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               last_nib;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [4:0]         nib_sum;

    // When both request, ptr_q picks the winner: 0 -> requester 0, 1 -> requester 1.
    assign grant0 = req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = req1_valid && (!req0_valid ||  ptr_q);

    assign req0_ready = (state_q == ST_IDLE) && !rst && grant0;
    assign req1_ready = (state_q == ST_IDLE) && !rst && grant1;
    assign accept     = req0_ready || req1_ready;

    assign last_nib   = (idx_q == IDX_W'(NIBBLES - 1));

    // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        a_nib = 4'd0;
        b_nib = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
            end
        end
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry_q};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (last_nib)  state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q   <= !grant1;
                id_q    <= grant1;
                idx_q   <= '0;
                carry_q <= grant1 ? req1_cin : req0_cin;
            end else if (state_q == ST_RUN) begin
                idx_q   <= idx_q + IDX_W'(1);
                carry_q <= nib_sum[4];
            end
        end
    end

    // NOTE: operand and sum registers carry no reset; outputs are masked outside DONE, so their contents never escape.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= grant1 ? req1_a : req0_a;
            b_q <= grant1 ? req1_b : req0_b;
        end
        if (state_q == ST_RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IDX_W'(i)) sum_q[i*4 +: 4] <= nib_sum[3:0];
            end
        end
    end

    // Masking with rst keeps a reset cycle from completing a response handshake.
    assign rsp_valid = (state_q == ST_DONE) && !rst;
    assign rsp_sum   = rsp_valid ? sum_q   : '0;
    assign rsp_cout  = rsp_valid ? carry_q : 1'b0;
    assign rsp_id    = rsp_valid ? id_q    : 1'b0;

endmodule

// File: tb/tb_pes_rca_sched.sv
// Self-checking bench for pes_rca_sched: directed scenarios followed by randomized traffic
// compared against a plain-arithmetic model of the round-robin scheduler and wide adder.
module tb_pes_rca_sched;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [W-1:0] rsp_sum;

    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    int           model_ptr   = 0;
    int           acc_cyc     = 0;
    int           last_acc    = 0;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_id;

    pes_rca_sched #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for an accept, checks the grant against the round-robin rule and
    // computes the expected response with plain wide arithmetic.
    task automatic wait_accept(output bit seen, output int who);
        int         exp_who;
        logic [W:0] full;
        seen = 1'b0;
        who  = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
            if (req0_ready || req1_ready) begin
                seen    = 1'b1;
                who     = req1_ready ? 1 : 0;
                exp_who = (req0_valid && req1_valid) ? model_ptr : (req1_valid ? 1 : 0);
                check("grant_id", 64'(who), 64'(exp_who));
                if (who == 1) full = {1'b0, req1_a} + {1'b0, req1_b} + (W+1)'(req1_cin);
                else          full = {1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(req0_cin);
                exp_sum  = full[W-1:0];
                exp_cout = full[W];
                exp_id   = (who == 1);
            end
            step();
        end
        check("accept_in_time", 64'(seen), 64'd1);
        if (seen) begin
            model_ptr = 1 - who;
            last_acc  = acc_cyc;
            acc_cyc   = cyc;
            // Latched operands must be immune to the client changing its inputs mid-operation.
            if (who == 1) begin
                req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
            end else begin
                req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            end
        end
    endtask

    task automatic finish_rsp(input int hold);
        rsp_ready = (hold == 0);
        for (int k = 0; k < NIBBLES; k++) begin
            @(negedge clk);
            check("rsp_valid_early", 64'(rsp_valid), 64'd0);
            check("ready_busy", 64'(req0_ready | req1_ready), 64'd0);
            step();
        end
        @(negedge clk);
        check("rsp_valid_on_time", 64'(rsp_valid), 64'd1);
        check("rsp_sum", 64'(rsp_sum), 64'(exp_sum));
        check("rsp_cout", 64'(rsp_cout), 64'(exp_cout));
        check("rsp_id", 64'(rsp_id), 64'(exp_id));
        for (int h = 0; h < hold; h++) begin
            step();
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_sum", 64'(rsp_sum), 64'(exp_sum));
            check("bp_cout", 64'(rsp_cout), 64'(exp_cout));
            check("bp_id", 64'(rsp_id), 64'(exp_id));
            check("bp_ready", 64'(req0_ready | req1_ready), 64'd0);
        end
        if (hold > 0) begin
            step();
            rsp_ready = 1'b1;
        end
        step();
        check("rsp_released", 64'(rsp_valid), 64'd0);
        check("ready0_return", 64'(req0_ready), 64'(req0_valid && (!req1_valid || model_ptr == 0)));
        check("ready1_return", 64'(req1_ready), 64'(req1_valid && (!req0_valid || model_ptr == 1)));
    endtask

    initial begin
        bit seen;
        int who;
        int rst_cyc;

        rst        = 1'b1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0FFF; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h5555; req1_b = 16'h1111; req1_cin = 1'b1;

        // Reset held two cycles with both requesters pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready0", 64'(req0_ready), 64'd0);
            check("rst_ready1", 64'(req1_ready), 64'd0);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
            check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
            check("rst_rsp_id", 64'(rsp_id), 64'd0);
            step();
        end
        rst       = 1'b0;
        model_ptr = 0;
        #1;
        check("post_rst_ready0", 64'(req0_ready), 64'd1);
        check("post_rst_ready1", 64'(req1_ready), 64'd0);

        // Contention: grants alternate starting with requester 0, issue interval NIBBLES+2.
        for (int i = 0; i < 4; i++) begin
            wait_accept(seen, who);
            if (seen) begin
                check("alt_grant", 64'(who), 64'(i % 2));
                if (i == 0) check("first_sum", 64'(exp_sum), 64'h2233);
                if (i > 0)  check("issue_interval", 64'(acc_cyc - last_acc), 64'(NIBBLES + 2));
                finish_rsp(0);
            end
        end

        // Full carry ripple from requester 1 alone.
        req0_valid = 1'b0;
        req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1;
        wait_accept(seen, who);
        if (seen) finish_rsp(0);

        // MSB carry-out from requester 0 alone.
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_a = 16'h8000; req0_b = 16'h8000; req0_cin = 1'b0;
        wait_accept(seen, who);
        if (seen) finish_rsp(0);

        // Backpressure: response held for several cycles.
        req0_a = 16'hA5C3; req0_b = 16'h3C5A; req0_cin = 1'b1;
        wait_accept(seen, who);
        if (seen) finish_rsp(5);

        // Reset during nibble 2 abandons the operation.
        req0_a = 16'hBEEF; req0_b = 16'h1357; req0_cin = 1'b0;
        wait_accept(seen, who);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(req0_ready | req1_ready), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        rst       = 1'b0;
        model_ptr = 0;
        rst_cyc   = cyc;
        req0_a = 16'h0F0F; req0_b = 16'h7777; req0_cin = 1'b1;
        #1;
        check("midrst_out_valid", 64'(rsp_valid), 64'd0);
        check("midrst_out_sum", 64'(rsp_sum), 64'd0);
        check("midrst_out_cout", 64'(rsp_cout), 64'd0);
        check("midrst_out_id", 64'(rsp_id), 64'd0);
        check("midrst_fresh_ready", 64'(req0_ready), 64'd1);
        wait_accept(seen, who);
        if (seen) begin
            check("midrst_accept_cycle", 64'(acc_cyc - rst_cyc), 64'd1);
            finish_rsp(0);
        end

        // Randomized traffic: random valids, operands and occasional backpressure.
        for (int r = 0; r < 24; r++) begin
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            if (!req0_valid && !req1_valid) req1_valid = 1'b1;
            req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
            wait_accept(seen, who);
            if (seen) finish_rsp(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
